// File: rtl/mul_issue_pipe.sv
// ---------------------------------------------------------------------------
// mul_issue_pipe
//   RV32M multiply issue/retire stage in front of a combinational
//   Booth/Wallace multiplier. Takes MUL/MULH/MULHSU/MULHU ops from execute
//   with a valid/ready handshake and decodes funct3 into operand sign
//   controls. Registered operands drive the multiplier. The stage captures
//   the wanted product half and retires results in order, each with its tag.
//   Backpressure collapses bubbles, and a flush kills every op in flight.
//
//   Pipeline: stage 1 holds the operands and drives the multiplier.
//   Stage 2 captures the selected product half. Stages 3..LAT are plain
//   delay registers. o_valid/o_result/o_tag come from stage LAT.
//
// Parameters
//   W      operand/result width (the multiplier supports 32 only)
//   TAG_W  width of the opaque tag (rd index)
//   LAT    number of register stages from accept to result, legal 2..4
//
// Ports
//   i_clk, i_rst          clock; asynchronous active-high reset
//   i_valid/o_ready       op request handshake from execute
//   i_funct3              000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
//   i_rs1, i_rs2, i_tag   multiplicand, multiplier, tag returned with result
//   i_flush               kill all in-flight ops and the same-cycle request
//   o_valid/i_ready       result handshake to the consumer
//   o_result, o_tag       selected product half and its tag
//   o_mul_x_sign/_y_sign  operand sign controls to the multiplier
//   o_mul_x, o_mul_y      operands to the multiplier
//   i_mul_hi, i_mul_lw    high/low product halves from the multiplier
// ---------------------------------------------------------------------------
module mul_issue_pipe #(
    parameter int W     = 32,
    parameter int TAG_W = 5,
    parameter int LAT   = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_funct3,
    input  logic [W-1:0]     i_rs1,
    input  logic [W-1:0]     i_rs2,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [W-1:0]     o_result,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_mul_x_sign,
    output logic             o_mul_y_sign,
    output logic [W-1:0]     o_mul_x,
    output logic [W-1:0]     o_mul_y,
    input  logic [W-1:0]     i_mul_hi,
    input  logic [W-1:0]     i_mul_lw
);

    // Bit k is the valid flag of stage k; bit 1 is the operand stage.
    logic [LAT:1]     vld;
    logic [LAT:1]     adv;
    logic             accept;

    // Decoded controls for the incoming op.
    logic             dec_x_sign;
    logic             dec_y_sign;
    logic             dec_hi;

    // Stage 1: operand registers.
    logic [W-1:0]     s1_x;
    logic [W-1:0]     s1_y;
    logic             s1_x_sign;
    logic             s1_y_sign;
    logic             s1_hi;
    logic [TAG_W-1:0] s1_tag;

    // Stages 2..LAT: result half and tag.
    logic [W-1:0]     st_res [2:LAT];
    logic [TAG_W-1:0] st_tag [2:LAT];

    // MULHU is the only op that treats rs1 as unsigned. MULHSU and MULHU
    // both treat rs2 as unsigned. Every op except MUL returns the high half.
    // funct3[2] ops never get past the accept term, so their decode does
    // not matter.
    always_comb begin
        dec_x_sign = ~(i_funct3[1] & i_funct3[0]);
        dec_y_sign = ~i_funct3[1];
        dec_hi     = |i_funct3[1:0];
    end

    // Stage k advances when it is empty or when stage k+1 advances, and the
    // last stage advances when the consumer takes the result. Unrolling that
    // chain gives: stage k advances unless stages k..LAT are all full while
    // the consumer stalls. A running AND computes this without reading adv
    // back into itself.
    always_comb begin : adv_chain
        logic run_full;
        // NOTE: every variable written here gets a value before any
        // conditional use, so no latch can be inferred.
        run_full = 1'b1;
        adv      = '0;
        for (int k = LAT; k >= 1; k--) begin
            run_full = run_full & vld[k];
            adv[k]   = i_ready | ~run_full;
        end
    end

    assign o_ready = adv[1];
    assign accept  = i_valid & o_ready & ~i_flush & ~i_funct3[2];

    // Valid bits. A flush clears all of them at once. Any request in the
    // same cycle is dropped, because accept already excludes i_flush.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every stage samples the values from before the edge.
            vld <= '0;
        end else if (i_flush) begin
            vld <= '0;
        end else begin
            if (adv[1]) vld[1] <= accept;
            for (int k = 2; k <= LAT; k++) begin
                if (adv[k]) vld[k] <= vld[k-1];
            end
        end
    end

    // Data registers load only when an op actually enters the stage. A held
    // stage therefore keeps o_mul_*, o_result and o_tag stable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: the data registers are reset too, not just the valid
            // bits, because the outputs must read zero during reset.
            s1_x      <= '0;
            s1_y      <= '0;
            s1_x_sign <= 1'b0;
            s1_y_sign <= 1'b0;
            s1_hi     <= 1'b0;
            s1_tag    <= '0;
            for (int k = 2; k <= LAT; k++) begin
                st_res[k] <= '0;
                st_tag[k] <= '0;
            end
        end else begin
            if (accept) begin
                s1_x      <= i_rs1;
                s1_y      <= i_rs2;
                s1_x_sign <= dec_x_sign;
                s1_y_sign <= dec_y_sign;
                s1_hi     <= dec_hi;
                s1_tag    <= i_tag;
            end
            // Only the selected half is kept. Overflow in the multiplier's
            // sign extension is dropped on purpose.
            if (adv[2] && vld[1]) begin
                st_res[2] <= s1_hi ? i_mul_hi : i_mul_lw;
                st_tag[2] <= s1_tag;
            end
            for (int k = 3; k <= LAT; k++) begin
                if (adv[k] && vld[k-1]) begin
                    st_res[k] <= st_res[k-1];
                    st_tag[k] <= st_tag[k-1];
                end
            end
        end
    end

    assign o_mul_x      = s1_x;
    assign o_mul_y      = s1_y;
    assign o_mul_x_sign = s1_x_sign;
    assign o_mul_y_sign = s1_y_sign;
    assign o_valid      = vld[LAT];
    assign o_result     = st_res[LAT];
    assign o_tag        = st_tag[LAT];

endmodule
